// File: rtl/seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer owning the program counter.
// Optional retired-instruction counter output enabled by defining SEQ_INSTCNT_EN.
module seq_ctrl #(
  parameter int unsigned    PcW       = 6,
  parameter logic [PcW-1:0] StartAddr = '0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           imem_ack_i,
  input  logic           halt_op_i,
  input  logic           wb_en_i,
  input  logic [PcW-1:0] pc_in_i,
  input  logic           pc_we_i,
  output logic [PcW-1:0] pc_o,
  output logic           imem_req_o,
  output logic           ir_we_o,
  output logic           alu_en_o,
  output logic           rf_we_o,
  output logic           busy_o,
  output logic           done_o,
`ifdef SEQ_INSTCNT_EN
  output logic [15:0]    instcnt_o,
`endif
  output logic [2:0]     state_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  state_e         state_q;
  logic [PcW-1:0] pc_q;
`ifdef SEQ_INSTCNT_EN
  logic [15:0]    instcnt_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pc_q      <= StartAddr;
`ifdef SEQ_INSTCNT_EN
      instcnt_q <= '0;
`endif
    end else begin
      case (state_q)
        StIdle, StHalt: begin
          if (start_i) begin
            state_q   <= StFetch;
            pc_q      <= StartAddr;
`ifdef SEQ_INSTCNT_EN
            instcnt_q <= '0;
`endif
          end
        end
        StFetch: begin
          if (imem_ack_i) state_q <= StDecode;
        end
        // A HALT instruction leaves pc pointing at itself.
        StDecode: state_q <= halt_op_i ? StHalt : StExec;
        StExec:   state_q <= StWb;
        StWb: begin
          state_q <= StFetch;
          pc_q    <= pc_we_i ? pc_in_i : pc_q + PcW'(1);
`ifdef SEQ_INSTCNT_EN
          if (instcnt_q != 16'hFFFF) instcnt_q <= instcnt_q + 16'd1;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pc_o       = pc_q;
  assign state_o    = state_q;
  assign imem_req_o = (state_q == StFetch);
  assign ir_we_o    = (state_q == StFetch) & imem_ack_i;
  assign alu_en_o   = (state_q == StExec);
  assign rf_we_o    = (state_q == StWb) & wb_en_i;
  assign busy_o     = (state_q == StFetch) | (state_q == StDecode) |
                      (state_q == StExec)  | (state_q == StWb);
  assign done_o     = (state_q == StHalt);
`ifdef SEQ_INSTCNT_EN
  assign instcnt_o  = instcnt_q;
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed self-checking bench for seq_ctrl; instcnt checks compile in with SEQ_INSTCNT_EN.
module tb_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i, imem_ack_i, halt_op_i, wb_en_i, pc_we_i;
  logic [5:0] pc_in_i, pc_o;
  logic       imem_req_o, ir_we_o, alu_en_o, rf_we_o, busy_o, done_o;
  logic [2:0] state_o;
`ifdef SEQ_INSTCNT_EN
  logic [15:0] instcnt_o;
`endif

  int checks = 0;
  int errors = 0;

  seq_ctrl #(
    .PcW       (6),
    .StartAddr (6'd0)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .imem_ack_i (imem_ack_i),
    .halt_op_i  (halt_op_i),
    .wb_en_i    (wb_en_i),
    .pc_in_i    (pc_in_i),
    .pc_we_i    (pc_we_i),
    .pc_o       (pc_o),
    .imem_req_o (imem_req_o),
    .ir_we_o    (ir_we_o),
    .alu_en_o   (alu_en_o),
    .rf_we_o    (rf_we_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
`ifdef SEQ_INSTCNT_EN
    .instcnt_o  (instcnt_o),
`endif
    .state_o    (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Walks one non-HALT instruction starting in FETCH with imem_ack held high.
  task automatic instr(input logic [5:0] exp_pc, input logic [5:0] exp_next,
                       input logic we_exec, input logic we_wb, input logic [5:0] tgt);
    check("fetch_state", state_o, 1);
    check("fetch_pc", pc_o, exp_pc);
    check("fetch_req", imem_req_o, 1);
    check("fetch_irwe", ir_we_o, 1);
    check("fetch_busy", busy_o, 1);
    cyc();
    check("dec_state", state_o, 2);
    check("dec_irwe", ir_we_o, 0);
    cyc();
    pc_we_i = we_exec;
    pc_in_i = tgt;
    wb_en_i = 1'b1;
    #1;
    check("exec_state", state_o, 3);
    check("exec_alu", alu_en_o, 1);
    check("exec_rfwe", rf_we_o, 0);
    cyc();
    pc_we_i = we_wb;
    #1;
    check("wb_state", state_o, 4);
    check("wb_rfwe", rf_we_o, 1);
    check("wb_alu", alu_en_o, 0);
    check("wb_pc", pc_o, exp_pc);
    cyc();
    pc_we_i = 1'b0;
    wb_en_i = 1'b0;
    check("next_state", state_o, 1);
    check("next_pc", pc_o, exp_next);
  endtask

  task automatic do_halt(input logic [5:0] exp_pc);
    check("hf_state", state_o, 1);
    cyc();
    halt_op_i = 1'b1;
    check("hd_state", state_o, 2);
    cyc();
    halt_op_i = 1'b0;
    check("halt_state", state_o, 5);
    check("halt_done", done_o, 1);
    check("halt_busy", busy_o, 0);
    check("halt_pc", pc_o, exp_pc);
    cyc();
    cyc();
    check("halt_hold", state_o, 5);
    check("halt_pc_hold", pc_o, exp_pc);
  endtask

  task automatic restart();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check("rs_state", state_o, 1);
    check("rs_pc", pc_o, 0);
    check("rs_done", done_o, 0);
  endtask

  initial begin
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    imem_ack_i = 1'b1;
    halt_op_i  = 1'b0;
    wb_en_i    = 1'b1;
    pc_we_i    = 1'b0;
    pc_in_i    = 6'd0;
    #2;
    check("rst_state", state_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_req", imem_req_o, 0);
    check("rst_irwe", ir_we_o, 0);
    check("rst_alu", alu_en_o, 0);
    check("rst_rfwe", rf_we_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
`ifdef SEQ_INSTCNT_EN
    check("rst_cnt", instcnt_o, 0);
`endif
    wb_en_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();
    cyc();
    check("idle_stay", state_o, 0);

    // Sequential stepping 0..5
    restart();
    for (int i = 0; i < 5; i++) instr(6'(i), 6'(i + 1), 1'b0, 1'b0, 6'd0);

    // Jump taken in WB, then jump request only in EXEC (ignored)
    instr(6'd5, 6'd40, 1'b0, 1'b1, 6'd40);
    instr(6'd40, 6'd41, 1'b1, 1'b0, 6'd17);

    // Fetch stall for 7 cycles
    imem_ack_i = 1'b0;
    #1;
    for (int k = 0; k < 7; k++) begin
      check("stall_state", state_o, 1);
      check("stall_pc", pc_o, 41);
      check("stall_req", imem_req_o, 1);
      check("stall_irwe", ir_we_o, 0);
      cyc();
    end
    imem_ack_i = 1'b1;
    #1;
    check("ack_irwe", ir_we_o, 1);
    cyc();
    check("ack_dec", state_o, 2);
    cyc();
    cyc();
    cyc();
    check("stall_next_pc", pc_o, 42);

    // Wrap 63 -> 0, then HALT at pc 1
    instr(6'd42, 6'd63, 1'b0, 1'b1, 6'd63);
    instr(6'd63, 6'd0, 1'b0, 1'b0, 6'd0);
    instr(6'd0, 6'd1, 1'b0, 1'b0, 6'd0);
    do_halt(6'd1);
`ifdef SEQ_INSTCNT_EN
    check("cnt_11", instcnt_o, 11);
`endif
    restart();
`ifdef SEQ_INSTCNT_EN
    check("cnt_clr", instcnt_o, 0);
`endif

    // start held while busy has no effect
    start_i = 1'b1;
    instr(6'd0, 6'd1, 1'b0, 1'b0, 6'd0);
    start_i = 1'b0;

    // Asynchronous reset during EXEC with wb_en high
    cyc();
    cyc();
    wb_en_i = 1'b1;
    check("pre_rst_exec", state_o, 3);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_state", state_o, 0);
    check("arst_pc", pc_o, 0);
    check("arst_alu", alu_en_o, 0);
    check("arst_busy", busy_o, 0);
    cyc();
    check("arst_rfwe", rf_we_o, 0);
    check("arst_hold", state_o, 0);
    wb_en_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Three instructions then HALT
    #1;
    restart();
    for (int i = 0; i < 3; i++) instr(6'(i), 6'(i + 1), 1'b0, 1'b0, 6'd0);
    do_halt(6'd3);
`ifdef SEQ_INSTCNT_EN
    check("cnt_3", instcnt_o, 3);
`endif
    restart();
`ifdef SEQ_INSTCNT_EN
    check("cnt_restart", instcnt_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
- Multi-cycle instruction sequencer for the N-queen processor core.
- Owns the 6-bit program counter and steps each instruction through FETCH, DECODE, EXEC and WB.
- Handshakes with instruction memory and strobes the IR, ALU and register file.
- Consumes the jump target and jump-enable produced by the jump-select stage; the sequencer is the only writer of the PC.

Parameters:
- PC_W, 6, program counter width; the address space is 2^PC_W words.
- START_ADDR, 0, PC value loaded on reset and on every accepted start.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  run request; sampled only in IDLE or HALT.
- imem_ack  input  1  instruction memory data valid for the current pc.
- halt_op  input  1  decoder flag, valid during DECODE: instruction is HALT.
- wb_en  input  1  decoder flag, held valid through WB: instruction writes the register file.
- pc_in  input  PC_W  jump target from the jump-select stage, valid in WB.
- pc_we  input  1  jump taken, from the jump-select stage, valid in WB.
- pc  output  PC_W  current program counter, drives the imem address.
- imem_req  output  1  fetch request.
- ir_we  output  1  instruction register load strobe.
- alu_en  output  1  ALU execute strobe.
- rf_we  output  1  register file write strobe.
- busy  output  1  high in FETCH, DECODE, EXEC and WB.
- done  output  1  high in HALT.
- state  output  3  FSM state, for debug.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5. Codes 6 and 7 return to IDLE on the next edge.
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, pc=START_ADDR;
  - imem_req, ir_we, alu_en, rf_we, busy and done all 0.
- Reset asserted mid-instruction aborts it immediately, with no rf_we or pc update.
- Output decoding:
  - imem_req, alu_en, busy and done are decoded from the state register only.
  - ir_we = (state==FETCH) & imem_ack.
  - rf_we = (state==WB) & wb_en.
- IDLE: start=1 loads pc=START_ADDR and moves to FETCH; otherwise stay.
- FETCH:
  - imem_req=1.
  - imem_ack=1 gives ir_we=1 for that cycle and moves to DECODE.
  - imem_ack=0 waits indefinitely with pc held stable.
- DECODE:
  - halt_op=1 moves to HALT, with pc unchanged and pointing at the HALT instruction.
  - Otherwise moves to EXEC.
- EXEC: alu_en=1 for exactly one cycle, then moves to WB. The jump-select stage registers its decision on this edge.
- WB:
  - pc_we=1: pc <= pc_in.
  - pc_we=0: pc <= pc+1 modulo 2^PC_W, so 63 wraps to 0.
  - Then moves to FETCH.
- HALT:
  - done=1 and busy=0; holds until start=1.
  - start=1 reloads pc=START_ADDR and moves to FETCH; done drops the same edge.
- start while busy is ignored and not queued.
- pc_we outside WB is ignored.
- imem_ack outside FETCH is ignored.
- Minimum instruction latency is 4 cycles (FETCH with same-cycle ack, DECODE, EXEC, WB).

Optional Feature:
- Macro: SEQ_INSTCNT_EN.
- Defined:
  - Adds output instcnt[15:0], the count of retired instructions.
  - Increments on each WB exit and saturates at 16'hFFFF.
  - Cleared to 0 by reset and by an accepted start.
  - A HALT instruction is not counted.
- Undefined: the port and its counter logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset, then start=1 for one cycle, with imem_ack tied 1, halt_op=0, pc_we=0 → pc steps 0,1,2,… every 4 cycles; ir_we, alu_en and WB each pulse once per instruction.
2. pc=5 in WB with pc_we=1 and pc_in=6'd40 → next FETCH shows pc=40 and imem_req=1. With pc_we=1 in EXEC only → pc=6.
3. Hold imem_ack=0 for 7 cycles in FETCH → state stays 1, pc and imem_req stable, no ir_we; ack on cycle 8 → DECODE on the next edge.
4. pc=63 and no jump → pc wraps to 0. Then halt_op=1 in DECODE → done=1, busy=0, pc held; start=1 → pc=0, FETCH, done=0.
5. Drive rst=0 in EXEC with wb_en=1 → immediately state=0, pc=START_ADDR, no rf_we pulse. start pulsed while busy → no effect on sequencing.
6. With SEQ_INSTCNT_EN defined, run 3 instructions then HALT → instcnt=3; start again → instcnt=0.
